// File: rtl/uart_pkg.sv
// Shared UART transmitter types and line-level constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/baud_gen.sv
// Bit-period down-counter: pulses bit_end in the last cycle of each serial bit.
module baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic clear,
  output logic bit_end
);

  localparam int              CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = en && (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load || bit_end) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte intake.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1 framing).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] valor,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_idx;
  logic       bit_end;
  logic       accept;
`ifdef UART_TX_PARITY_EN
  logic       parity;
`endif

  assign ready  = (state == IDLE);
  assign busy   = ~ready;
  assign accept = valid && ready;

  baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .en     (busy),
    .load   (accept),
    .clear  (bit_end && (state == STOP)),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register is a handful of flops, not a memory, so it is
      // reset along with the rest to give a fully known post-reset state.
      state   <= IDLE;
      tx      <= IDLE_LEVEL;
      shreg   <= '0;
      bit_idx <= '0;
      done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            shreg   <= valor;
            tx      <= START_LEVEL;
            bit_idx <= '0;
            state   <= START;
`ifdef UART_TX_PARITY_EN
            parity  <= ^valor;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            // The 3-bit index rolls 7 -> 0 on the last data bit.
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx    <= parity;
              state <= PARITY;
`else
              tx    <= IDLE_LEVEL;
              state <= STOP;
`endif
            end else begin
              tx    <= shreg[0];
              shreg <= shreg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx    <= IDLE_LEVEL;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized self-checking bench for uart_tx against a bit-list frame model.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef bit bit_q_t[$];

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] valor = 8'h00;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .valor(valor),
    .valid(valid),
    .ready(ready),
    .tx   (tx),
    .busy (busy),
    .done (done)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  // Reference line levels: start, 8 data bits LSB first, optional even parity, stop.
  function automatic bit_q_t frame_of(input logic [7:0] b);
    bit_q_t q;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    q.push_back(bit'($countones(b) % 2));
`endif
    q.push_back(1'b1);
    return q;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " tx"},    tx,    1'b1);
    check({tag, " ready"}, ready, 1'b1);
    check({tag, " busy"},  busy,  1'b0);
    check({tag, " done"},  done,  1'b0);
  endtask

  // Caller has raised valid with valor=b at a negedge while the DUT is idle.
  // Checks every cycle of the frame and the done cycle. With chain set, valid
  // stays high with nxt in the done cycle; glitch_at >= 0 pokes valid/valor
  // mid-frame to show they are ignored.
  task automatic run_frame(input string tag, input logic [7:0] b, input bit chain,
                           input logic [7:0] nxt, input int glitch_at);
    bit_q_t exp = frame_of(b);
    @(posedge clk);
    for (int c = 0; c < FRAME_BITS * CPB; c++) begin
      @(negedge clk);
      if (c == 0) valid = 1'b0;
      if (glitch_at >= 0 && c == glitch_at) begin
        valor = 8'hFF;
        valid = 1'b1;
      end
      if (glitch_at >= 0 && c == glitch_at + 8) valid = 1'b0;
      check($sformatf("%s tx c%0d", tag, c),    tx,    exp[c / CPB]);
      check($sformatf("%s ready c%0d", tag, c), ready, 1'b0);
      check($sformatf("%s done c%0d", tag, c),  done,  1'b0);
    end
    @(negedge clk);
    check({tag, " done pulse"}, done,  1'b1);
    check({tag, " done ready"}, ready, 1'b1);
    check({tag, " done tx"},    tx,    1'b1);
    if (chain) begin
      valor = nxt;
      valid = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] b;

    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Single one-cycle-valid frames, directed then random.
    valor = 8'hA5; valid = 1'b1;
    run_frame("a5", 8'hA5, 1'b0, 8'h00, -1);
    @(negedge clk);
    check_idle("after a5");

    valor = 8'h07; valid = 1'b1;
    run_frame("07", 8'h07, 1'b0, 8'h00, -1);
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      valor = b; valid = 1'b1;
      run_frame($sformatf("rnd%0d", i), b, 1'b0, 8'h00, -1);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Back-to-back: second start bit directly after the done cycle.
    valor = 8'h3C; valid = 1'b1;
    run_frame("b2b1", 8'h3C, 1'b1, 8'hC3, -1);
    run_frame("b2b2", 8'hC3, 1'b0, 8'h00, -1);
    @(negedge clk);

    // valor/valid disturbed mid-frame: latched byte is sent, no extra frame.
    b = 8'($urandom) & 8'h7E;
    valor = b; valid = 1'b1;
    run_frame("hold", b, 1'b0, 8'h00, 10);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("noextra tx c%0d", c),    tx,    1'b1);
      check($sformatf("noextra ready c%0d", c), ready, 1'b1);
    end

    // Reset during data bit 3, then a clean frame.
    valor = 8'h96; valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      valid = 1'b0;
      if (c == 17) rst = 1'b1;
    end
    @(negedge clk);
    check_idle("midrst");
    rst = 1'b0;
    valor = 8'h55; valid = 1'b1;
    run_frame("55", 8'h55, 1'b0, 8'h00, -1);
    @(negedge clk);

    // Reset wins over valid in the same cycle.
    rst = 1'b1; valor = 8'h00; valid = 1'b1;
    @(negedge clk);
    check_idle("rstvalid");
    rst = 1'b0; valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_idle("rstvalid after");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
